// File: rtl/hazard_squash_ctrl_pkg.sv
// Shared encodings and types for the hazard / squash controller.
// Holds the PC mux and forwarding select codes, the tracking entry and the FSM states.
package hazard_squash_ctrl_pkg;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_DEC_TGT = 2'd1;
  localparam logic [1:0] PC_EX_TGT  = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } trk_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_WAIT_RES
  } state_t;

  // A load still in EX has no data yet, so it never forwards from that stage.
  function automatic logic [1:0] fwd_pick(trk_entry_t ex_e, trk_entry_t mem_e,
                                          trk_entry_t wb_e, logic [4:0] rs);
    if (rs == 5'd0)                               return FWD_RF;
    if (ex_e.v && !ex_e.ld && ex_e.rd == rs)      return FWD_EX;
    if (mem_e.v && mem_e.rd == rs)                return FWD_MEM;
    if (wb_e.v && wb_e.rd == rs)                  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_squash_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && cnt_reg != '1) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/hazard_squash_ctrl.sv
// Load-use stall, operand forwarding and control-flow squash control beside ID/EX.
// Tracks in-flight writers through EX/MEM/WB; no datapath of its own.
module hazard_squash_ctrl
  import hazard_squash_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [5:0]       reg_rd_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             dec_is_load,
  input  logic             resolve,
  input  logic             select_target_pc,
  input  logic             squash_after_J,
  input  logic             squash_after_JALR,
  input  logic             ex_taken,
  output logic             stall,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       pc_sel,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  trk_entry_t ex_reg, mem_reg, wb_reg, ex_next;
  state_t     state_reg, state_next;

  logic [4:0] rs_id   [2];
  logic [1:0] fwd_sel [2];
  logic [1:0] ld_hit;
  logic       ex_flush, load_use, jal_acc, ctl_acc;

  assign rs_id[0] = rs1_id;
  assign rs_id[1] = rs2_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign fwd_sel[gi] = fwd_pick(ex_reg, mem_reg, wb_reg, rs_id[gi]);
      assign ld_hit[gi]  = ex_reg.v && ex_reg.ld && rs_id[gi] != 5'd0 &&
                           ex_reg.rd == rs_id[gi];
    end
  endgenerate

  // A resolving EX redirect wins over everything sitting in decode.
  assign ex_flush = !rst && state_reg == ST_WAIT_RES && ex_taken;
  assign load_use = !rst && dec_valid && (|ld_hit);
  assign stall    = load_use && !ex_flush;
  assign jal_acc  = !rst && dec_valid && squash_after_J && select_target_pc &&
                    !stall && !ex_flush;
  assign ctl_acc  = !rst && dec_valid && (resolve || squash_after_JALR) &&
                    !stall && !ex_flush;

  assign flush_if    = ex_flush || jal_acc;
  assign flush_id    = ex_flush;
  assign pc_sel      = ex_flush ? PC_EX_TGT : (jal_acc ? PC_DEC_TGT : PC_PLUS4);
  assign fwd_rs1_sel = rst ? FWD_RF : fwd_sel[0];
  assign fwd_rs2_sel = rst ? FWD_RF : fwd_sel[1];

  always_comb begin
    ex_next = '0;
    if (dec_valid && !stall && !flush_id) begin
      ex_next.v  = reg_rd_id[5] && reg_rd_id[4:0] != 5'd0;
      ex_next.rd = reg_rd_id[4:0];
      ex_next.ld = dec_is_load;
    end
  end

  always_comb begin
    state_next = ST_RUN;
    if (!ex_flush && ctl_acc) state_next = ST_WAIT_RES;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ex_reg    <= ex_next;
      mem_reg   <= ex_reg;
      wb_reg    <= mem_reg;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_if),
    .cnt (squash_cnt)
  );

endmodule

// File: tb/tb_hazard_squash_ctrl.sv
// Directed bench for hazard_squash_ctrl with hand-computed expectations.
module tb_hazard_squash_ctrl;
  import hazard_squash_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [5:0]    reg_rd_id;
  logic [4:0]    rs1_id, rs2_id;
  logic          dec_is_load, resolve, select_target_pc;
  logic          squash_after_J, squash_after_JALR, ex_taken;
  logic          stall, flush_if, flush_id;
  logic [1:0]    pc_sel, fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] stall_cnt, squash_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_squash_ctrl #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .dec_valid         (dec_valid),
    .reg_rd_id         (reg_rd_id),
    .rs1_id            (rs1_id),
    .rs2_id            (rs2_id),
    .dec_is_load       (dec_is_load),
    .resolve           (resolve),
    .select_target_pc  (select_target_pc),
    .squash_after_J    (squash_after_J),
    .squash_after_JALR (squash_after_JALR),
    .ex_taken          (ex_taken),
    .stall             (stall),
    .flush_if          (flush_if),
    .flush_id          (flush_id),
    .pc_sel            (pc_sel),
    .fwd_rs1_sel       (fwd_rs1_sel),
    .fwd_rs2_sel       (fwd_rs2_sel),
    .stall_cnt         (stall_cnt),
    .squash_cnt        (squash_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // j drives both squash_after_J and select_target_pc (a decoded JAL).
  task automatic drv(input string name, input logic v, input logic [5:0] rd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic ld,
                     input logic res, input logic j, input logic jr, input logic tk);
    dec_valid = v; reg_rd_id = rd; rs1_id = r1; rs2_id = r2; dec_is_load = ld;
    resolve = res; squash_after_J = j; select_target_pc = j;
    squash_after_JALR = jr; ex_taken = tk;
    #2;
    $display("[%0t] %s: stall=%0b fif=%0b fid=%0b pc=%0d f1=%0d f2=%0d sc=%0d qc=%0d",
             $time, name, stall, flush_if, flush_id, pc_sel, fwd_rs1_sel, fwd_rs2_sel,
             stall_cnt, squash_cnt);
  endtask

  task automatic idle(input logic tk);
    drv("idle", 1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tk);
  endtask

  initial begin
    rst = 1'b1;
    // JAL presented during reset must not redirect
    drv("rst_jal", 1'b1, 6'h21, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_stall", stall, 0);
    chk("rst_flush_if", flush_if, 0);
    chk("rst_flush_id", flush_id, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_fwd1", fwd_rs1_sel, 0);
    chk("rst_fwd2", fwd_rs2_sel, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_squash_cnt", squash_cnt, 0);
    tick();
    rst = 1'b0;

    // load x5 ; add x6,x5,x1
    drv("ld_x5", 1'b1, 6'h25, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_no_stall_first", stall, 0);
    tick();
    drv("add_x6_x5", 1'b1, 6'h26, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", stall, 1);
    chk("lu_no_ex_fwd", fwd_rs1_sel, 0);
    tick();
    drv("add_x6_x5_re", 1'b1, 6'h26, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_done", stall, 0);
    chk("lu_fwd_mem", fwd_rs1_sel, 2);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();

    // forwarding distance 1/2/3 and x0
    drv("add_x3", 1'b1, 6'h23, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv("sub_x3", 1'b1, 6'h00, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_ex", fwd_rs1_sel, 1);
    chk("fwd_x0", fwd_rs2_sel, 0);
    tick();
    drv("use_x3_x6", 1'b1, 6'h00, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_mem", fwd_rs1_sel, 2);
    chk("fwd_wb", fwd_rs2_sel, 3);
    tick();
    drv("use_x3_wr_x0", 1'b1, 6'h20, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_wb2", fwd_rs1_sel, 3);
    tick();
    drv("add_x7", 1'b1, 6'h27, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_none", fwd_rs1_sel, 0);
    tick();
    drv("add_x7_x7", 1'b1, 6'h27, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_ex_x7", fwd_rs1_sel, 1);
    tick();
    drv("use_x7", 1'b1, 6'h00, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_ex_priority", fwd_rs1_sel, 1);
    tick();
    idle(1'b0); tick(); idle(1'b0); tick(); idle(1'b0); tick();

    // JAL
    drv("jal", 1'b1, 6'h21, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jal_pc_sel", pc_sel, 1);
    chk("jal_flush_if", flush_if, 1);
    chk("jal_flush_id", flush_id, 0);
    tick();
    idle(1'b0);
    chk("jal_squash_cnt", squash_cnt, 1);
    chk("jal_pc_after", pc_sel, 0);
    tick();

    // taken branch
    drv("beq", 1'b1, 6'h00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_acc_flush_if", flush_if, 0);
    chk("br_acc_pc_sel", pc_sel, 0);
    tick();
    drv("add_x9_taken", 1'b1, 6'h29, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("br_tk_pc_sel", pc_sel, 2);
    chk("br_tk_flush_if", flush_if, 1);
    chk("br_tk_flush_id", flush_id, 1);
    tick();
    drv("use_x9", 1'b1, 6'h00, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_tk_ex_bubble", fwd_rs1_sel, 0);
    chk("br_tk_squash_cnt", squash_cnt, 2);
    tick();

    // not-taken branch
    drv("bne", 1'b1, 6'h00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    chk("br_nt_flush_if", flush_if, 0);
    chk("br_nt_pc_sel", pc_sel, 0);
    tick();
    idle(1'b1);
    chk("br_nt_back_in_run", flush_if, 0);
    tick();

    // EX redirect vs decode JAL with load-use hazard
    drv("br_ld_x5", 1'b1, 6'h25, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv("jal_use_x5_tk", 1'b1, 6'h21, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_pc_sel", pc_sel, 2);
    chk("ovr_stall", stall, 0);
    chk("ovr_flush_id", flush_id, 1);
    tick();
    drv("ld_x5_b", 1'b1, 6'h25, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_squash_cnt", squash_cnt, 3);
    chk("ovr_stall_cnt", stall_cnt, 1);
    tick();

    // stall blocks JAL until re-presented
    drv("jal_use_x5", 1'b1, 6'h21, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sj_stall", stall, 1);
    chk("sj_pc_sel", pc_sel, 0);
    chk("sj_flush_if", flush_if, 0);
    tick();
    drv("jal_use_x5_re", 1'b1, 6'h21, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sj_re_stall", stall, 0);
    chk("sj_re_pc_sel", pc_sel, 1);
    tick();
    idle(1'b0);
    chk("sj_squash_cnt", squash_cnt, 4);
    chk("sj_stall_cnt", stall_cnt, 2);
    tick();

    // reset while in WAIT_RES with a valid load in EX
    drv("br_ld_x5_r", 1'b1, 6'h25, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv("jal_use_x5_r", 1'b1, 6'h21, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_pc_sel", pc_sel, 0);
    chk("mid_rst_flush_if", flush_if, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_squash_cnt", squash_cnt, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_jal", pc_sel, 1);
    tick();
    idle(1'b1);
    chk("post_rst_run", flush_if, 0);
    tick();

    // saturation: repeated load-use hazards, one stall every other cycle
    for (int i = 0; i < 40; i++) begin
      drv("sat_ld", 1'b1, 6'h25, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0);
    chk("sat_stall_cnt", stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
